// File: rtl/led_bank_arbiter.sv
// Round-robin arbiter sharing the 8-LED bank between NREQ pattern sources.
// Each owner holds the bank for at most SLICE cycles while others are waiting.
module led_bank_arbiter #(
  parameter int unsigned NREQ         = 4,
  parameter int unsigned SLICE        = 12000000,
  parameter logic [7:0]  IDLE_PATTERN = 8'h00
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] pattern,
  output logic [NREQ-1:0]   grant,
  output logic [7:0]        leds,
  output logic              busy
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(SLICE);

  typedef enum logic [0:0] {StIdle, StOwn} state_e;

  state_e          state_q;
  logic [IW-1:0]   last_q;
  logic [CW-1:0]   cnt_q;

  logic [7:0]      pat_arr [NREQ];
  logic [IW-1:0]   sel_idx;
  logic            sel_valid;
  logic [NREQ-1:0] sel_onehot;
  logic [7:0]      sel_pat;
  logic [7:0]      own_pat;
  logic            others;
  logic            slice_end;

  function automatic logic [IW-1:0] wrap(input int unsigned v);
    return IW'(v % NREQ);
  endfunction

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      pat_arr[i] = pattern[8*i +: 8];
    end
  end

  // First pending request searching last+1, last+2, ... modulo NREQ.
  always_comb begin
    sel_idx   = '0;
    sel_valid = 1'b0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      if (!sel_valid && req[wrap(32'(last_q) + i)]) begin
        sel_valid = 1'b1;
        sel_idx   = wrap(32'(last_q) + i);
      end
    end
  end

  assign sel_onehot = NREQ'(1) << sel_idx;
  assign sel_pat    = pat_arr[sel_idx];
  assign own_pat    = pat_arr[last_q];
  assign others     = |(req & ~grant);
  assign slice_end  = (cnt_q == CW'(SLICE - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      grant   <= '0;
      leds    <= IDLE_PATTERN;
      busy    <= 1'b0;
      cnt_q   <= '0;
      last_q  <= IW'(NREQ - 1);
    end else begin
      unique case (state_q)
        StIdle: begin
          if (sel_valid) begin
            state_q <= StOwn;
            grant   <= sel_onehot;
            leds    <= sel_pat;
            busy    <= 1'b1;
            last_q  <= sel_idx;
            cnt_q   <= '0;
          end else begin
            leds    <= IDLE_PATTERN;
          end
        end
        StOwn: begin
          if (!req[last_q]) begin
            // Release: with req[owner] low, any valid selection is another requester.
            if (sel_valid) begin
              grant  <= sel_onehot;
              leds   <= sel_pat;
              last_q <= sel_idx;
              cnt_q  <= '0;
            end else begin
              state_q <= StIdle;
              grant   <= '0;
              leds    <= IDLE_PATTERN;
              busy    <= 1'b0;
              cnt_q   <= '0;
            end
          end else if (slice_end && others) begin
            grant  <= sel_onehot;
            leds   <= sel_pat;
            last_q <= sel_idx;
            cnt_q  <= '0;
          end else if (slice_end) begin
            cnt_q <= '0;
            leds  <= own_pat;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            leds  <= own_pat;
          end
        end
        default: begin
          state_q <= StIdle;
          grant   <= '0;
          leds    <= IDLE_PATTERN;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Directed bench for led_bank_arbiter with NREQ=4, SLICE=4, IDLE_PATTERN=0.
module tb_led_bank_arbiter;

  logic        clk;
  logic        rstn;
  logic [3:0]  req;
  logic [31:0] pattern;
  logic [3:0]  grant;
  logic [7:0]  leds;
  logic        busy;

  int n_cmp;
  int n_err;

  led_bank_arbiter #(
    .NREQ        (4),
    .SLICE       (4),
    .IDLE_PATTERN(8'h00)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .req    (req),
    .pattern(pattern),
    .grant  (grant),
    .leds   (leds),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step();
    step();
    rstn = 1'b1;
  endtask

  function automatic logic [7:0] owner_pat(input logic [3:0] g);
    case (g)
      4'b0001: return 8'h11;
      4'b0010: return 8'h22;
      4'b0100: return 8'h33;
      4'b1000: return 8'h44;
      default: return 8'h00;
    endcase
  endfunction

  logic [3:0] rr_seq [4];

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    rstn    = 1'b0;
    req     = 4'hF;
    pattern = 32'h44332211;
    rr_seq[0] = 4'b0001;
    rr_seq[1] = 4'b0010;
    rr_seq[2] = 4'b1000;
    rr_seq[3] = 4'b0001;

    // Reset with all requests high
    step();
    step();
    check_eq("rst_grant", 32'(grant), 32'h0);
    check_eq("rst_leds", 32'(leds), 32'h00);
    check_eq("rst_busy", 32'(busy), 32'h0);
    rstn = 1'b1;
    step();
    check_eq("post_rst_grant", 32'(grant), 32'b0001);
    check_eq("post_rst_leds", 32'(leds), 32'h11);
    check_eq("post_rst_busy", 32'(busy), 32'h1);
    req = 4'b0000;
    step();
    check_eq("idle_grant", 32'(grant), 32'h0);
    check_eq("idle_busy", 32'(busy), 32'h0);

    // Single requester and pattern tracking
    pattern[23:16] = 8'hA5;
    req = 4'b0100;
    step();
    check_eq("single_grant", 32'(grant), 32'b0100);
    check_eq("single_leds", 32'(leds), 32'hA5);
    pattern[23:16] = 8'h3C;
    step();
    check_eq("single_leds_upd", 32'(leds), 32'h3C);
    req = 4'b0000;
    step();
    check_eq("single_rel_grant", 32'(grant), 32'h0);
    check_eq("single_rel_leds", 32'(leds), 32'h00);
    check_eq("single_rel_busy", 32'(busy), 32'h0);
    pattern[23:16] = 8'h33;

    // Round-robin preemption, 4 cycles per owner, no idle gaps
    do_reset();
    req = 4'b1011;
    for (int k = 0; k < 13; k++) begin
      step();
      check_eq($sformatf("rr_grant_%0d", k), 32'(grant), 32'(rr_seq[k/4]));
      check_eq($sformatf("rr_leds_%0d", k), 32'(leds), 32'(owner_pat(rr_seq[k/4])));
      check_eq($sformatf("rr_busy_%0d", k), 32'(busy), 32'h1);
    end

    // Slice wrap without contention
    req = 4'b1000;
    for (int k = 0; k < 20; k++) begin
      step();
      check_eq($sformatf("wrap_grant_%0d", k), 32'(grant), 32'b1000);
      check_eq($sformatf("wrap_busy_%0d", k), 32'(busy), 32'h1);
    end
    check_eq("wrap_leds", 32'(leds), 32'h44);

    // Release handover at counter=1 restarts the slice
    req = 4'b0000;
    step();
    check_eq("ho_idle", 32'(grant), 32'h0);
    req = 4'b0010;
    step();
    check_eq("ho_own1", 32'(grant), 32'b0010);
    req = 4'b1010;
    step();
    check_eq("ho_own1_c1", 32'(grant), 32'b0010);
    req = 4'b1000;
    step();
    check_eq("ho_grant", 32'(grant), 32'b1000);
    check_eq("ho_leds", 32'(leds), 32'h44);
    check_eq("ho_busy", 32'(busy), 32'h1);
    req = 4'b1010;
    for (int k = 1; k < 4; k++) begin
      step();
      check_eq($sformatf("ho_hold_%0d", k), 32'(grant), 32'b1000);
    end
    step();
    check_eq("ho_preempt", 32'(grant), 32'b0010);
    check_eq("ho_preempt_leds", 32'(leds), 32'h22);

    // Asynchronous reset between edges while requester 1 owns the bank
    req = 4'b1011;
    #2;
    rstn = 1'b0;
    #1;
    check_eq("arst_grant", 32'(grant), 32'h0);
    check_eq("arst_leds", 32'(leds), 32'h00);
    check_eq("arst_busy", 32'(busy), 32'h0);
    step();
    rstn = 1'b1;
    step();
    check_eq("arst_prio_grant", 32'(grant), 32'b0001);
    check_eq("arst_prio_leds", 32'(leds), 32'h11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/led_bank_arbiter.md
Name: led_bank_arbiter

Overview:
- Round-robin arbiter that shares the 8-LED bank of the iCEstick between NREQ independent pattern sources.
- Each requester asks for the bank and supplies an 8-bit pattern. The arbiter grants one requester at a time for a bounded time slice and drives the LEDs from the winner.
- The arbiter sits between the application blocks and the top-level LED0..LED7 pins. When no requester holds the bank, the LEDs are driven to the idle pattern (all off by default).

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- SLICE, 12000000, maximum cycles a requester owns the bank while others wait (1 s at 12 MHz); must be >= 2.
- IDLE_PATTERN, 8'h00, LED value driven when no grant is active.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- req  in  NREQ  request per requester; level-sensitive; held high while the bank is wanted.
- pattern  in  8*NREQ  pattern for requester i at bits [8i+7:8i].
- grant  out  NREQ  one-hot (or zero) registered grant.
- leds  out  8  registered LED drive; bit k goes to LEDk.
- busy  out  1  registered; high when any grant is active.

Behaviour:
- Reset (rstn low, asynchronous):
  - grant=0, leds=IDLE_PATTERN, busy=0.
  - Slice counter cleared.
  - Round-robin pointer last=NREQ-1, so requester 0 has first priority after reset.
- All outputs are registered. Asserting rstn mid-ownership drops grant immediately; there is no partial state after release.
- States:
  - IDLE: grant=0.
  - OWN: exactly one grant bit set.
- Selection function: the first i with req[i]=1, searching last+1, last+2, ... modulo NREQ.
- IDLE transitions:
  - If any req is high at a clock edge, enter OWN on that edge.
  - Set grant to the selected one-hot value, last=selected index, counter=0.
  - leds=pattern of the selected requester in the same edge. Latency from req high to grant/leds valid is 1 cycle.
- OWN, owner g (evaluated each edge, in priority order):
  1. req[g]=0 (release):
     - If another req is pending, hand over directly to the selection (no idle cycle); counter=0.
     - Otherwise go to IDLE: grant=0, leds=IDLE_PATTERN, busy=0.
  2. counter==SLICE-1 and another req is pending (preempt): hand over to the selection; counter=0.
  3. counter==SLICE-1 and no other req is pending: g keeps the bank; counter wraps to 0.
  4. Otherwise: counter increments.
- LED drive while granted:
  - leds is re-registered from pattern of the current owner every cycle, so pattern changes appear 1 cycle later.
  - On handover, leds takes the new owner's pattern on the same edge grant changes.
- Simultaneous events:
  - Release on the same edge as slice expiry is handled as a release.
  - Multiple new requests are resolved only by round-robin order, never by index alone.
- Fairness: a continuously requesting requester waits at most (NREQ-1)*SLICE+1 cycles for grant.
- Widths:
  - counter is $clog2(SLICE) bits.
  - busy = |grant, registered alongside grant.
- req bits are assumed synchronous to clk; no synchronizers are inside this block.

Test Plan (NREQ=4, SLICE=4, IDLE_PATTERN=8'h00 unless stated):
- Reset: hold rstn=0 with req=4'hF, then release -> grant=0, leds=8'h00, busy=0 during reset. One cycle after release, grant=4'b0001, leds=pattern0.
- Single requester: req=4'b0100, pattern2=8'hA5 -> next cycle grant=4'b0100, leds=8'hA5. Change pattern2 to 8'h3C -> leds=8'h3C one cycle later. Deassert req -> next cycle grant=0, leds=8'h00.
- Round-robin preempt: req=4'b1011 held constant -> grant sequence 0001, 1000 is skipped until its turn, giving 0001 → 0010 → 1000 → 0001. Each owner holds exactly 4 cycles; there are no idle cycles between owners.
- Slice wrap with no contention: only req[3] high for 20 cycles -> grant=4'b1000 for all 20 cycles and busy stays 1.
- Release handover: owner 1 drops req at counter=1 while req[3] is high -> next cycle grant=4'b1000, leds=pattern3, counter restarts at 0.
- Async reset mid-ownership: assert rstn low between clock edges while grant=4'b0010 -> grant=0 and leds=8'h00 immediately, without waiting for a clk edge. After release, requester 0 has first priority again.
